// File: rtl/latch_bank_pkg.sv
// Shared types and helpers for the latch_bank hold register bank.
package latch_bank_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_FOLLOW  = 2'b00;
    localparam mode_t MODE_EDGE    = 2'b01;
    localparam mode_t MODE_ONESHOT = 2'b10;
    localparam mode_t MODE_FROZEN  = 2'b11;

    // Readout select width; a single channel still gets a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/latch_bank_if.sv
// Control, data and readout bundle of the latch_bank; master drives captures, slave is the bank.
interface latch_bank_if
    import latch_bank_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) ();
    localparam int unsigned SEL_W = sel_width(CHANNELS);

    mode_t                      mode;
    logic [CHANNELS-1:0]        en;
    logic [CHANNELS*WIDTH-1:0]  d;
    logic                       clr;
    logic [SEL_W-1:0]           sel;
    logic [CHANNELS*WIDTH-1:0]  q_all;
    logic [WIDTH-1:0]           q_sel;
    logic [CHANNELS-1:0]        valid;
    logic [CHANNELS-1:0]        upd;

    modport master (
        output mode, en, d, clr, sel,
        input  q_all, q_sel, valid, upd
    );

    modport slave (
        input  mode, en, d, clr, sel,
        output q_all, q_sel, valid, upd
    );
endinterface

// File: rtl/latch_bank_chan.sv
// One hold channel: captured value, enable history, valid/lock flags and update pulse.
module latch_bank_chan
    import latch_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  mode_t            mode_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] q_o,
    output logic             valid_o,
    output logic             upd_o
);
    logic [WIDTH-1:0] q_q, q_d;
    logic             en_prev_q, en_prev_d;
    logic             valid_q, valid_d;
    logic             lock_q, lock_d;
    logic             upd_q, upd_d;
    logic             rise;
    logic             load;

    // Load decision and next state; clr outranks load, enable history always advances.
    always_comb begin
        rise      = en_i & ~en_prev_q;
        load      = 1'b0;
        q_d       = q_q;
        valid_d   = valid_q;
        lock_d    = lock_q;
        upd_d     = 1'b0;
        en_prev_d = en_i;

        case (mode_i)
            MODE_FOLLOW:  load = en_i;
            MODE_EDGE:    load = rise;
            MODE_ONESHOT: load = rise & ~lock_q;
            default:      load = 1'b0;
        endcase

        if (clr_i) begin
            q_d     = '0;
            valid_d = 1'b0;
            lock_d  = 1'b0;
        end else if (load) begin
            q_d     = d_i;
            valid_d = 1'b1;
            upd_d   = 1'b1;
            if (mode_i == MODE_ONESHOT) begin
                lock_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q       <= '0;
            en_prev_q <= 1'b0;
            valid_q   <= 1'b0;
            lock_q    <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            q_q       <= q_d;
            en_prev_q <= en_prev_d;
            valid_q   <= valid_d;
            lock_q    <= lock_d;
            upd_q     <= upd_d;
        end
    end

    assign q_o     = q_q;
    assign valid_o = valid_q;
    assign upd_o   = upd_q;

endmodule

// File: rtl/latch_bank.sv
// Multi-channel clocked hold register bank: per-channel capture plus packed and selected readout.
module latch_bank
    import latch_bank_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic         clk,
    input  logic         rst,
    latch_bank_if.slave  bus
);
    localparam int unsigned SEL_W = sel_width(CHANNELS);

    logic [WIDTH-1:0]          q_arr [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] q_all_w;
    logic [CHANNELS-1:0]       valid_w;
    logic [CHANNELS-1:0]       upd_w;
    logic [WIDTH-1:0]          q_sel_c;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        latch_bank_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk_i   (clk),
            .rst_i   (rst),
            .mode_i  (bus.mode),
            .en_i    (bus.en[i]),
            .d_i     (bus.d[i*WIDTH +: WIDTH]),
            .clr_i   (bus.clr),
            .q_o     (q_arr[i]),
            .valid_o (valid_w[i]),
            .upd_o   (upd_w[i])
        );
        assign q_all_w[i*WIDTH +: WIDTH] = q_arr[i];
    end

    // Selects past the last channel read as zero.
    always_comb begin
        q_sel_c = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (bus.sel == SEL_W'(i)) begin
                q_sel_c = q_arr[i];
            end
        end
    end

    assign bus.q_all = q_all_w;
    assign bus.valid = valid_w;
    assign bus.upd   = upd_w;
    assign bus.q_sel = q_sel_c;

endmodule

// File: tb/tb_latch_bank.sv
// Self-checking bench for latch_bank: directed vector table, random run against a behavioural model,
// plus readout/size corner configurations.
module tb_latch_bank;
    import latch_bank_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    latch_bank_if #(.WIDTH(8), .CHANNELS(4)) m_if ();
    latch_bank_if #(.WIDTH(8), .CHANNELS(3)) r_if ();
    latch_bank_if #(.WIDTH(1), .CHANNELS(1)) t_if ();

    latch_bank #(.WIDTH(8), .CHANNELS(4)) u_main  (.clk(clk), .rst(rst), .bus(m_if));
    latch_bank #(.WIDTH(8), .CHANNELS(3)) u_three (.clk(clk), .rst(rst), .bus(r_if));
    latch_bank #(.WIDTH(1), .CHANNELS(1)) u_tiny  (.clk(clk), .rst(rst), .bus(t_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  en;
        logic [31:0] d;
        logic        clr;
        logic [1:0]  sel;
        logic [31:0] exp_q;
        logic [3:0]  exp_valid;
        logic [3:0]  exp_upd;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model of the 4x8 bank.
    logic [7:0] mq    [4];
    bit         mvalid[4];
    bit         mlock [4];
    bit         mprev [4];
    bit         mupd  [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int idx);
        return w[idx*8 +: 8];
    endfunction

    task automatic model_clear_all();
        for (int c = 0; c < 4; c++) begin
            mq[c] = '0; mvalid[c] = 0; mlock[c] = 0; mprev[c] = 0; mupd[c] = 0;
        end
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        logic [31:0] dv;
        bit rise, ld;
        dv = m_if.d;
        if (rst) begin
            model_clear_all();
        end else begin
            for (int c = 0; c < 4; c++) begin
                rise = m_if.en[c] && !mprev[c];
                case (m_if.mode)
                    2'b00:   ld = m_if.en[c];
                    2'b01:   ld = rise;
                    2'b10:   ld = rise && !mlock[c];
                    default: ld = 0;
                endcase
                mupd[c] = 0;
                if (m_if.clr) begin
                    mq[c] = '0; mvalid[c] = 0; mlock[c] = 0;
                end else if (ld) begin
                    mq[c] = dv[c*8 +: 8];
                    mvalid[c] = 1;
                    mupd[c] = 1;
                    if (m_if.mode == 2'b10) mlock[c] = 1;
                end
                mprev[c] = m_if.en[c];
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] eq;
        logic [3:0]  ev, eu;
        for (int c = 0; c < 4; c++) begin
            eq[c*8 +: 8] = mq[c];
            ev[c] = mvalid[c];
            eu[c] = mupd[c];
        end
        check({tag, ".q_all"}, 64'(m_if.q_all), 64'(eq));
        check({tag, ".valid"}, 64'(m_if.valid), 64'(ev));
        check({tag, ".upd"},   64'(m_if.upd),   64'(eu));
        check({tag, ".q_sel"}, 64'(m_if.q_sel), 64'(mq[int'(m_if.sel)]));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        r_if.mode = MODE_FROZEN; r_if.en = '0; r_if.d = '0; r_if.clr = 1'b0; r_if.sel = '0;
        t_if.mode = MODE_FROZEN; t_if.en = '0; t_if.d = '0; t_if.clr = 1'b0; t_if.sel = '0;

        // Reset with enables and data all ones.
        rst = 1'b1;
        m_if.mode = MODE_FOLLOW; m_if.en = 4'hF; m_if.d = 32'hFFFF_FFFF; m_if.clr = 1'b0; m_if.sel = '0;
        tick();
        tick();
        check("rst.q_all", 64'(m_if.q_all), 64'h0);
        check("rst.valid", 64'(m_if.valid), 64'h0);
        check("rst.upd",   64'(m_if.upd),   64'h0);
        for (int s = 0; s < 4; s++) begin
            m_if.sel = 2'(s);
            #1;
            check($sformatf("rst.q_sel%0d", s), 64'(m_if.q_sel), 64'h0);
        end
        rst = 1'b0;
        m_if.en = '0;

        // mode, en, d, clr, sel, exp q_all, exp valid, exp upd
        vecs.push_back('{2'd0, 4'b0001, 32'hDEAD_BE11, 1'b0, 2'd0, 32'h0000_0011, 4'b0001, 4'b0001});
        vecs.push_back('{2'd0, 4'b0001, 32'hDEAD_BE22, 1'b0, 2'd0, 32'h0000_0022, 4'b0001, 4'b0001});
        vecs.push_back('{2'd0, 4'b0001, 32'hDEAD_BE33, 1'b0, 2'd1, 32'h0000_0033, 4'b0001, 4'b0001});
        vecs.push_back('{2'd0, 4'b0000, 32'hDEAD_BE44, 1'b0, 2'd0, 32'h0000_0033, 4'b0001, 4'b0000});
        vecs.push_back('{2'd1, 4'b0010, 32'h0000_A500, 1'b0, 2'd1, 32'h0000_A533, 4'b0011, 4'b0010});
        vecs.push_back('{2'd1, 4'b0010, 32'h0000_5A00, 1'b0, 2'd1, 32'h0000_A533, 4'b0011, 4'b0000});
        vecs.push_back('{2'd1, 4'b0010, 32'h0000_5A00, 1'b0, 2'd1, 32'h0000_A533, 4'b0011, 4'b0000});
        vecs.push_back('{2'd1, 4'b0010, 32'h0000_5A00, 1'b0, 2'd1, 32'h0000_A533, 4'b0011, 4'b0000});
        vecs.push_back('{2'd1, 4'b0010, 32'h0000_5A00, 1'b0, 2'd1, 32'h0000_A533, 4'b0011, 4'b0000});
        vecs.push_back('{2'd1, 4'b0000, 32'h0000_5A00, 1'b0, 2'd1, 32'h0000_A533, 4'b0011, 4'b0000});
        vecs.push_back('{2'd1, 4'b0010, 32'h0000_5A00, 1'b0, 2'd1, 32'h0000_5A33, 4'b0011, 4'b0010});
        vecs.push_back('{2'd1, 4'b0010, 32'h0000_5A00, 1'b0, 2'd0, 32'h0000_5A33, 4'b0011, 4'b0000});
        vecs.push_back('{2'd2, 4'b0100, 32'h0001_0000, 1'b0, 2'd2, 32'h0001_5A33, 4'b0111, 4'b0100});
        vecs.push_back('{2'd2, 4'b0000, 32'h0002_0000, 1'b0, 2'd2, 32'h0001_5A33, 4'b0111, 4'b0000});
        vecs.push_back('{2'd2, 4'b0100, 32'h0002_0000, 1'b0, 2'd2, 32'h0001_5A33, 4'b0111, 4'b0000});
        vecs.push_back('{2'd2, 4'b0100, 32'h0002_0000, 1'b1, 2'd2, 32'h0000_0000, 4'b0000, 4'b0000});
        vecs.push_back('{2'd2, 4'b0000, 32'h0003_0000, 1'b0, 2'd2, 32'h0000_0000, 4'b0000, 4'b0000});
        vecs.push_back('{2'd2, 4'b0100, 32'h0003_0000, 1'b0, 2'd2, 32'h0003_0000, 4'b0100, 4'b0100});
        vecs.push_back('{2'd0, 4'b1000, 32'h7E00_0000, 1'b1, 2'd3, 32'h0000_0000, 4'b0000, 4'b0000});
        vecs.push_back('{2'd0, 4'b1000, 32'h7E00_0000, 1'b0, 2'd3, 32'h7E00_0000, 4'b1000, 4'b1000});
        vecs.push_back('{2'd3, 4'b1111, 32'hFFFF_FFFF, 1'b0, 2'd3, 32'h7E00_0000, 4'b1000, 4'b0000});
        vecs.push_back('{2'd3, 4'b0000, 32'hFFFF_FFFF, 1'b0, 2'd2, 32'h7E00_0000, 4'b1000, 4'b0000});
        vecs.push_back('{2'd3, 4'b1111, 32'hFFFF_FFFF, 1'b0, 2'd3, 32'h7E00_0000, 4'b1000, 4'b0000});

        foreach (vecs[i]) begin
            m_if.mode = vecs[i].mode;
            m_if.en   = vecs[i].en;
            m_if.d    = vecs[i].d;
            m_if.clr  = vecs[i].clr;
            m_if.sel  = vecs[i].sel;
            tick();
            check($sformatf("vec%0d.q_all", i), 64'(m_if.q_all), 64'(vecs[i].exp_q));
            check($sformatf("vec%0d.valid", i), 64'(m_if.valid), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d.upd", i),   64'(m_if.upd),   64'(vecs[i].exp_upd));
            check($sformatf("vec%0d.q_sel", i), 64'(m_if.q_sel),
                  64'(byte_of(vecs[i].exp_q, int'(vecs[i].sel))));
        end

        // Clear with enables low so the model starts from a known state.
        m_if.mode = MODE_FOLLOW; m_if.en = '0; m_if.clr = 1'b1;
        tick();
        model_clear_all();
        m_if.clr = 1'b0;
        check_model("clr_sync");

        // Randomised run against the model; mode is kept for several cycles so edges matter.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) m_if.mode = 2'($urandom_range(0, 3));
            m_if.en  = 4'($urandom);
            m_if.d   = $urandom;
            m_if.clr = ($urandom_range(0, 19) == 0);
            m_if.sel = 2'($urandom);
            rst      = ($urandom_range(0, 79) == 0);
            model_step();
            tick();
            check_model($sformatf("rnd%0d", n));
        end
        rst = 1'b0;

        // Reset all banks before the readout and single-bit configurations.
        rst = 1'b1;
        tick();
        rst = 1'b0;

        r_if.mode = MODE_FOLLOW; r_if.en = 3'b111; r_if.d = 24'h33_2211;
        t_if.mode = MODE_FOLLOW; t_if.en = 1'b1;   t_if.d = 1'b0;
        tick();
        check("three.q_all", 64'(r_if.q_all), 64'h33_2211);
        check("three.valid", 64'(r_if.valid), 64'h7);
        check("three.upd",   64'(r_if.upd),   64'h7);
        check("tiny.q0",     64'(t_if.q_all), 64'h0);
        check("tiny.upd0",   64'(t_if.upd),   64'h1);
        check("tiny.valid0", 64'(t_if.valid), 64'h1);
        r_if.en = '0;
        for (int s = 0; s < 4; s++) begin
            logic [31:0] exp_sel;
            exp_sel = (s < 3) ? 32'((s + 1) * 32'h11) : 32'h0;
            r_if.sel = 2'(s);
            #1;
            check($sformatf("three.q_sel%0d", s), 64'(r_if.q_sel), 64'(exp_sel));
        end

        t_if.d = 1'b1;
        tick();
        check("tiny.q1",   64'(t_if.q_all), 64'h1);
        check("tiny.upd1", 64'(t_if.upd),   64'h1);
        t_if.en = 1'b0; t_if.d = 1'b0;
        tick();
        check("tiny.hold_q",   64'(t_if.q_all), 64'h1);
        check("tiny.hold_upd", 64'(t_if.upd),   64'h0);
        t_if.sel = 1'b0;
        #1;
        check("tiny.q_sel0", 64'(t_if.q_sel), 64'h1);
        t_if.sel = 1'b1;
        #1;
        check("tiny.q_sel1", 64'(t_if.q_sel), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
